// File: rtl/alu_pipe.sv
// Clocked ALU: single-cycle add/sub/logic/shift ops and an iterative shift-add multiply,
// with valid/ready on both the operand side and the result side.
module alu_pipe #(
    parameter  int WIDTH = 8,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic [SHW-1:0]   shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_hi,
    output logic             zero,
    output logic             carry,
    output logic             overflow
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SHL = 3'b100;
    localparam logic [2:0] OP_SHR = 3'b101;
    localparam logic [2:0] OP_ASR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_HOLD} state_t;

    state_t             r_state;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_y;
    logic [WIDTH-1:0]   r_yhi;
    logic               r_zero;
    logic               r_carry;
    logic               r_ovf;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_acc;
    logic [CW-1:0]      r_cnt;

    logic               w_accept;
    logic               w_sub;
    logic [WIDTH-1:0]   w_b_eff;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_shl;
    logic [WIDTH:0]     w_shr;
    logic [WIDTH:0]     w_asr;
    logic [WIDTH-1:0]   w_y;
    logic               w_c;
    logic               w_v;
    logic [2*WIDTH-1:0] w_acc_nxt;

    // HOLD can take a new op in the same cycle the consumer drains the current result.
    assign in_ready = !rst && (r_state == S_IDLE || (r_state == S_HOLD && out_ready));
    assign w_accept = in_valid && in_ready;

    always_comb begin
        w_sub   = (op == OP_SUB);
        w_b_eff = w_sub ? ~b : b;
        w_sum   = {1'b0, a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_sub};
        // Extra bit on the shifted-out side captures the last bit lost (0 when shamt is 0).
        w_shl   = {1'b0, a} << shamt;
        w_shr   = {a, 1'b0} >> shamt;
        w_asr   = $signed({a, 1'b0}) >>> shamt;
        w_y     = '0;
        w_c     = 1'b0;
        w_v     = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                w_y = w_sum[WIDTH-1:0];
                w_c = w_sum[WIDTH];
                w_v = (a[WIDTH-1] == w_b_eff[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: w_y = a & b;
            OP_OR:  w_y = a | b;
            OP_SHL: begin
                w_y = w_shl[WIDTH-1:0];
                w_c = w_shl[WIDTH];
            end
            OP_SHR: begin
                w_y = w_shr[WIDTH:1];
                w_c = w_shr[0];
            end
            OP_ASR: begin
                w_y = w_asr[WIDTH:1];
                w_c = w_asr[0];
            end
            default: ;
        endcase
    end

    assign w_acc_nxt = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_y         <= '0;
            r_yhi       <= '0;
            r_zero      <= 1'b0;
            r_carry     <= 1'b0;
            r_ovf       <= 1'b0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                S_MUL: begin
                    // One extra cycle after the last partial product to publish the result.
                    if (r_cnt == CW'(WIDTH)) begin
                        r_y         <= r_acc[WIDTH-1:0];
                        r_yhi       <= r_acc[2*WIDTH-1:WIDTH];
                        r_zero      <= (r_acc[WIDTH-1:0] == '0);
                        r_carry     <= (r_acc[2*WIDTH-1:WIDTH] != '0);
                        r_ovf       <= (r_acc[2*WIDTH-1:WIDTH] != '0);
                        r_out_valid <= 1'b1;
                        r_state     <= S_HOLD;
                    end else begin
                        r_acc    <= w_acc_nxt;
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= r_mplier >> 1;
                        r_cnt    <= r_cnt + CW'(1);
                    end
                end
                S_HOLD: begin
                    if (out_ready && !in_valid) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase

            if (w_accept) begin
                if (op == OP_MUL) begin
                    r_mcand     <= {{WIDTH{1'b0}}, a};
                    r_mplier    <= b;
                    r_acc       <= '0;
                    r_cnt       <= '0;
                    r_out_valid <= 1'b0;
                    r_state     <= S_MUL;
                end else begin
                    r_y         <= w_y;
                    r_yhi       <= '0;
                    r_zero      <= (w_y == '0);
                    r_carry     <= w_c;
                    r_ovf       <= w_v;
                    r_out_valid <= 1'b1;
                    r_state     <= S_HOLD;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign y         = r_y;
    assign y_hi      = r_yhi;
    assign zero      = r_zero;
    assign carry     = r_carry;
    assign overflow  = r_ovf;

endmodule
